// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter that shares one UART transmitter
// among num_req_p valid/ready byte streams. A granted requester keeps the
// transmitter until it sends a byte flagged last or until max_burst_p bytes
// have gone out, after which the search restarts at the next requester.
module uart_tx_arbiter #(
    parameter int num_req_p    = 3,
    parameter int data_width_p = 8,
    parameter int max_burst_p  = 64
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [num_req_p-1:0]                req_v_i,
    input  logic [num_req_p*data_width_p-1:0]   req_data_i,
    input  logic [num_req_p-1:0]                req_last_i,
    output logic [num_req_p-1:0]                req_ready_and_o,
    output logic                                tx_v_o,
    output logic [data_width_p-1:0]             tx_o,
    input  logic                                tx_ready_and_i,
    output logic [num_req_p-1:0]                grant_o,
    output logic                                busy_o,
    output logic                                forced_release_o
);

    localparam int ptr_w_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1;
    localparam int cnt_w_lp = $clog2(max_burst_p + 1);
    localparam logic [ptr_w_lp-1:0]  last_idx_lp = ptr_w_lp'(num_req_p - 1);
    localparam logic [cnt_w_lp-1:0]  limit_lp    = cnt_w_lp'(max_burst_p);
    localparam logic [num_req_p-1:0] one_lp      = num_req_p'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t                 r_state;
    logic [ptr_w_lp-1:0]    r_ptr;
    logic [ptr_w_lp-1:0]    r_g;
    logic [num_req_p-1:0]   r_grant;
    logic [cnt_w_lp-1:0]    r_cnt;

    logic                       w_found;
    logic [ptr_w_lp-1:0]        w_sel;
    logic [ptr_w_lp-1:0]        w_idx;
    logic                       w_run;
    logic                       w_v;
    logic                       w_last;
    logic [data_width_p-1:0]    w_data;
    logic                       w_xfer;
    logic                       w_limit;

    // Requester index after idx, wrapping explicitly so non-power-of-two
    // requester counts never land on an unused index.
    function automatic logic [ptr_w_lp-1:0] next_idx(input logic [ptr_w_lp-1:0] idx);
        logic [ptr_w_lp-1:0] nxt;
        nxt = (idx == last_idx_lp) ? {ptr_w_lp{1'b0}} : (idx + ptr_w_lp'(1));
        return nxt;
    endfunction

    // Round-robin search: first valid requester at or after r_ptr.
    always_comb begin
        w_found = 1'b0;
        w_sel   = r_ptr;
        w_idx   = r_ptr;
        for (int i = 0; i < num_req_p; i++) begin
            w_sel   = (!w_found && req_v_i[w_idx]) ? w_idx : w_sel;
            w_found = w_found | req_v_i[w_idx];
            w_idx   = next_idx(w_idx);
        end
    end

    // Combinational pass-through of the granted stream; everything is held
    // at zero while reset is asserted so an aborted lock never leaks a byte.
    always_comb begin
        w_run   = ~reset & (r_state == ST_LOCK);
        w_v     = req_v_i[r_g];
        w_last  = req_last_i[r_g];
        w_data  = req_data_i[int'(r_g) * data_width_p +: data_width_p];
        tx_v_o  = w_run & w_v;
        tx_o    = w_run ? w_data : {data_width_p{1'b0}};
        req_ready_and_o  = (w_run & tx_ready_and_i) ? r_grant : {num_req_p{1'b0}};
        w_xfer           = w_run & w_v & tx_ready_and_i;
        w_limit          = ((r_cnt + cnt_w_lp'(1)) == limit_lp);
        forced_release_o = w_xfer & ~w_last & w_limit;
        grant_o          = reset ? {num_req_p{1'b0}} : r_grant;
        busy_o           = w_run;
    end

    // Arbitration FSM: one IDLE cycle to pick a requester, then LOCK until
    // a last byte or the burst limit releases it.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_ptr   <= {ptr_w_lp{1'b0}};
            r_g     <= {ptr_w_lp{1'b0}};
            r_grant <= {num_req_p{1'b0}};
            r_cnt   <= {cnt_w_lp{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_state <= ST_LOCK;
                        r_g     <= w_sel;
                        r_grant <= one_lp << w_sel;
                        r_cnt   <= {cnt_w_lp{1'b0}};
                    end
                end
                ST_LOCK: begin
                    if (w_xfer) begin
                        if (w_last || w_limit) begin
                            r_state <= ST_IDLE;
                            r_grant <= {num_req_p{1'b0}};
                            r_ptr   <= next_idx(r_g);
                            r_cnt   <= {cnt_w_lp{1'b0}};
                        end else begin
                            r_cnt   <= r_cnt + cnt_w_lp'(1);
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_grant <= {num_req_p{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter among N byte-stream requesters, e.g. the RX loopback buffer, an error/status reporter and the FPGA host response path.
- Grants are round-robin and packet-locked: once granted, a requester keeps the transmitter until it presents a byte flagged last, or until a fairness burst limit is reached.
- Sits between the requesters' valid/ready byte interfaces and the uart_tx input handshake.

Parameters:
- num_req_p, 3: number of requesters (2..8).
- data_width_p, 8: byte width; matches the UART data bits.
- max_burst_p, 64: maximum bytes per grant before forced release (1..255).

Ports:
- clock  input  1  clock
- reset  input  1  reset, synchronous, active-high
- req_v_i  input  num_req_p  per-requester byte valid
- req_data_i  input  num_req_p*data_width_p  per-requester byte; requester k occupies bits [k*data_width_p +: data_width_p]
- req_last_i  input  num_req_p  byte is the final byte of the packet
- req_ready_and_o  output  num_req_p  per-requester ready; high only for the granted requester
- tx_v_o  output  1  byte valid to uart_tx
- tx_o  output  data_width_p  byte to uart_tx
- tx_ready_and_i  input  1  ready from uart_tx
- grant_o  output  num_req_p  one-hot current grant; all zeros when idle
- busy_o  output  1  high in LOCK
- forced_release_o  output  1  one-cycle pulse when max_burst_p ends a grant

Behaviour:
- Reset: state=IDLE, rr_ptr=0, burst_cnt=0, grant=0. All outputs are 0 during reset and in the first cycle after reset.
- Handshake: a transfer occurs when tx_v_o & tx_ready_and_i. The granted requester sees the same transfer as req_v_i[g] & req_ready_and_o[g].
- State IDLE:
  - tx_v_o=0 and all req_ready_and_o=0.
  - If any req_v_i is high, select the first set bit searching from rr_ptr upward with wrap-around.
  - Register the selection as g, go to LOCK, clear burst_cnt.
  - Arbitration costs exactly one cycle: the first byte can transfer at the earliest in the cycle after the request is seen.
- State LOCK:
  - tx_v_o = req_v_i[g], tx_o = req_data_i[g], req_ready_and_o[g] = tx_ready_and_i, all other readies 0.
  - The path is combinational pass-through, with no data buffering in the arbiter.
  - The requester may drop valid mid-packet; the lock is held and bytes from other requesters are never interleaved.
  - On each transfer, burst_cnt increments.
  - If the transfer has req_last_i[g]=1, go to IDLE and set rr_ptr=(g+1) mod num_req_p.
  - Else, if burst_cnt+1 == max_burst_p, go to IDLE, set rr_ptr=(g+1) mod num_req_p, and pulse forced_release_o for that cycle.
  - If last and the limit coincide, the release is treated as last and forced_release_o stays 0.
- Outputs: grant_o = onehot(g) in LOCK, 0 in IDLE. busy_o = (state==LOCK).
- Back-to-back grants: after a release there is always one IDLE cycle, even when the same or another requester is still valid.
- Single requester repeatedly valid: it is re-granted every packet; no starvation occurs because rr_ptr rotates past it.
- Width rules:
  - burst_cnt is $clog2(max_burst_p+1) bits wide and never wraps, because the release happens at max_burst_p.
  - rr_ptr is $clog2(num_req_p) bits wide; its wrap is explicit modulo num_req_p, so non-power-of-two num_req_p works.
- Reset mid-packet: reset aborts the lock immediately. The next cycle is IDLE with rr_ptr=0, and any partially sent packet is the requester's responsibility.
- Protocol requirement: req_data_i and req_last_i are stable while valid and not ready, per the valid/ready-and convention. The arbiter does not check this.

Test Plan:
- Reset, then req0 sends 3 bytes 0x41,0x42,0x43 (last on 0x43) with tx_ready_and_i=1:
  - grant_o=001 one cycle after valid.
  - tx_o shows 0x41,0x42,0x43 on consecutive cycles.
  - grant_o returns to 000 after 0x43.
- All 3 requesters continuously valid with 1-byte packets: grant order is 0,1,2,0,1,2, with one IDLE cycle between grants.
- req1 locked; req1 drops valid for 5 cycles mid-packet while req0 and req2 are valid: no other grant occurs, tx_v_o=0 for those 5 cycles, and the packet then completes.
- max_burst_p=4, req2 sends 10 bytes without last:
  - release after byte 4 with forced_release_o pulsed exactly once.
  - then req0, if valid, is granted before req2 resumes.
- tx_ready_and_i held low 30 cycles mid-packet: byte 0x55 stays on tx_o, req_ready_and_o[g]=0 throughout, and exactly one transfer occurs when ready rises.
- Assert reset during byte 2 of a packet from req2: the following cycle shows busy_o=0, grant_o=0 and tx_v_o=0, and the next arbitration starts searching from req0.
